// File: rtl/reg_bank_addr_unit_pkg.sv
// Shared widths and constants for the decode-stage register bank and address unit.
package reg_bank_addr_unit_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 1 << ADDR_W;
    localparam int JUMP_W = 28;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : reg_bank_addr_unit_pkg

// File: rtl/reg_bank_addr_unit_reg_bank_core.sv
// 32x32 register bank: one synchronous write port, two gated combinational read ports.
module reg_bank_core
    import reg_bank_addr_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] dir_a,
    input  logic [ADDR_W-1:0] dir_b,
    input  logic [ADDR_W-1:0] dir_wra,
    input  logic [DATA_W-1:0] di,
    input  logic              reg_rd,
    input  logic              reg_wr,
    output logic [DATA_W-1:0] doa,
    output logic [DATA_W-1:0] dob
);

    logic [DATA_W-1:0] regs [NREGS];

    // NOTE: every entry is cleared by reset, so this array builds as flops, not a RAM macro;
    // state is updated with non-blocking assignments so all entries change together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_wr && (dir_wra != REG_ZERO)) begin
            regs[dir_wra] <= di;
        end
    end

    // Register zero is forced to read 0 even before the first reset has cleared it.
    assign doa = (reg_rd && (dir_a != REG_ZERO)) ? regs[dir_a] : '0;
    assign dob = (reg_rd && (dir_b != REG_ZERO)) ? regs[dir_b] : '0;

endmodule : reg_bank_core

// File: rtl/reg_bank_addr_unit.sv
// Decode-stage datapath: register bank plus jump-target concatenation and branch-offset shift.
module reg_bank_addr_unit
    import reg_bank_addr_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] dir_a,
    input  logic [ADDR_W-1:0] dir_b,
    input  logic [ADDR_W-1:0] dir_wra,
    input  logic [DATA_W-1:0] di,
    input  logic              reg_rd,
    input  logic              reg_wr,
    output logic [DATA_W-1:0] doa,
    output logic [DATA_W-1:0] dob,
    input  logic [JUMP_W-1:0] output_jump,
    input  logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] output_concat,
    input  logic [DATA_W-1:0] immediate,
    output logic [DATA_W-1:0] output_imm
);

    reg_bank_core u_reg_bank_core (
        .clk     (clk),
        .reset   (reset),
        .dir_a   (dir_a),
        .dir_b   (dir_b),
        .dir_wra (dir_wra),
        .di      (di),
        .reg_rd  (reg_rd),
        .reg_wr  (reg_wr),
        .doa     (doa),
        .dob     (dob)
    );

    // Jump target keeps the PC's 256 MB region; branch offset is the word offset in bytes.
    assign output_concat = {pc[DATA_W-1:JUMP_W], output_jump};
    assign output_imm    = {immediate[DATA_W-3:0], 2'b00};

    logic unused_bits;
    assign unused_bits = ^{pc[JUMP_W-1:0], immediate[DATA_W-1:DATA_W-2]};

endmodule : reg_bank_addr_unit

// File: tb/tb_reg_bank_addr_unit.sv
// Directed self-checking bench for reg_bank_addr_unit using an expected-value queue.
module tb_reg_bank_addr_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  dir_a, dir_b, dir_wra;
    logic [31:0] di;
    logic        reg_rd, reg_wr;
    logic [31:0] doa, dob;
    logic [27:0] output_jump;
    logic [31:0] pc;
    logic [31:0] output_concat;
    logic [31:0] immediate;
    logic [31:0] output_imm;

    typedef enum int { SEL_DOA, SEL_DOB, SEL_CONCAT, SEL_IMM } sel_e;

    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t queue_exp[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_bank_addr_unit dut (
        .clk           (clk),
        .reset         (reset),
        .dir_a         (dir_a),
        .dir_b         (dir_b),
        .dir_wra       (dir_wra),
        .di            (di),
        .reg_rd        (reg_rd),
        .reg_wr        (reg_wr),
        .doa           (doa),
        .dob           (dob),
        .output_jump   (output_jump),
        .pc            (pc),
        .output_concat (output_concat),
        .immediate     (immediate),
        .output_imm    (output_imm)
    );

    function automatic logic [31:0] observe(sel_e sel);
        case (sel)
            SEL_DOA:    return doa;
            SEL_DOB:    return dob;
            SEL_CONCAT: return output_concat;
            default:    return output_imm;
        endcase
    endfunction

    task automatic push(input string tag, input sel_e sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        queue_exp.push_back(e);
    endtask

    // Settle combinational outputs, then compare everything queued so far.
    task automatic check();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (queue_exp.size() > 0) begin
            e   = queue_exp.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r_pc, r_imm;
        logic [27:0] r_jump;

        reset = 1'b1; reg_rd = 1'b1; reg_wr = 1'b0;
        dir_a = '0; dir_b = '0; dir_wra = '0; di = '0;
        pc = '0; output_jump = '0; immediate = '0;
        next_edge();
        next_edge();
        dir_a = 5'd5; dir_b = 5'd31;
        push("reset_doa", SEL_DOA, 32'h0);
        push("reset_dob", SEL_DOB, 32'h0);
        check();
        reset = 1'b0;

        for (int a = 0; a < 32; a++) begin
            dir_a = 5'(a);
            dir_b = 5'(31 - a);
            push($sformatf("post_reset_doa_%0d", a), SEL_DOA, 32'h0);
            push($sformatf("post_reset_dob_%0d", a), SEL_DOB, 32'h0);
            check();
        end

        // Write reg 5; same-cycle read must still see the old value.
        reg_wr = 1'b1; dir_wra = 5'd5; di = 32'hDEADBEEF; dir_a = 5'd5;
        push("rdw_old", SEL_DOA, 32'h0);
        check();
        next_edge();
        reg_wr = 1'b0;
        push("write_r5", SEL_DOA, 32'hDEADBEEF);
        check();

        reg_wr = 1'b1; dir_wra = 5'd9; di = 32'h13579BDF;
        next_edge();
        reg_wr = 1'b0; dir_b = 5'd9;
        push("write_r9_dob", SEL_DOB, 32'h13579BDF);
        push("r5_kept",      SEL_DOA, 32'hDEADBEEF);
        check();

        reg_rd = 1'b0;
        push("rd_off_doa", SEL_DOA, 32'h0);
        push("rd_off_dob", SEL_DOB, 32'h0);
        check();
        reg_rd = 1'b1;

        reg_wr = 1'b1; dir_wra = 5'd0; di = 32'h12345678;
        next_edge();
        reg_wr = 1'b0; dir_b = 5'd0;
        push("reg_zero", SEL_DOB, 32'h0);
        check();

        // Reset wins over a write in the same cycle.
        reset = 1'b1; reg_wr = 1'b1; dir_wra = 5'd7; di = 32'hA5A5A5A5;
        next_edge();
        reset = 1'b0; reg_wr = 1'b0;
        dir_a = 5'd7; dir_b = 5'd5;
        push("rst_prio_r7", SEL_DOA, 32'h0);
        push("rst_clr_r5",  SEL_DOB, 32'h0);
        check();
        dir_a = 5'd9;
        push("rst_clr_r9", SEL_DOA, 32'h0);
        check();

        pc = 32'hA0000010; output_jump = 28'h0000040;
        push("concat_a", SEL_CONCAT, 32'hA0000040);
        check();
        pc = 32'h3FFFFFFC; output_jump = 28'hFFFFFFC;
        push("concat_b", SEL_CONCAT, 32'h3FFFFFFC);
        check();

        immediate = 32'h00000004;
        push("imm_4", SEL_IMM, 32'h00000010);
        check();
        immediate = 32'hFFFFFFFE;
        push("imm_neg2", SEL_IMM, 32'hFFFFFFF8);
        check();
        immediate = 32'h00007FFF;
        push("imm_7fff", SEL_IMM, 32'h0001FFFC);
        check();
        immediate = 32'hFFFFFFFF;
        push("imm_neg1", SEL_IMM, 32'hFFFFFFFC);
        check();

        for (int k = 0; k < 8; k++) begin
            r_pc   = $urandom;
            r_jump = 28'($urandom);
            r_imm  = $urandom;
            pc = r_pc; output_jump = r_jump; immediate = r_imm;
            push($sformatf("concat_rand_%0d", k), SEL_CONCAT,
                 (r_pc & 32'hF000_0000) | {4'h0, r_jump});
            push($sformatf("imm_rand_%0d", k), SEL_IMM, r_imm * 32'd4);
            check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_bank_addr_unit
